cpu54_wb_arbiter: RTL

- Writer-side front end for the CPU54 32x32 register file's single write port.
- Merges writeback results from two producers into one registered write per cycle:
  - A: the single-cycle ALU/load pipeline.
  - B: the multicycle MUL/DIV unit.
- Buffers B results in a small FIFO.
- Keeps a per-register busy scoreboard so decode can stall on RAW hazards against in-flight multicycle results.

---
 rtl/cpu54_wb_arbiter_pkg.sv | 14 +
 rtl/cpu54_wb_fifo.sv | 55 +++++
 rtl/cpu54_wb_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu54_wb_arbiter_pkg.sv
// Shared types and sizes for the CPU54 register-file writeback front end.
// The wb_entry_t record is what travels through the multicycle result FIFO.
package cpu54_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/cpu54_wb_fifo.sv
// Circular FIFO for multicycle writeback results.
// DEPTH must be a power of two so the pointers wrap naturally at AW bits.
module cpu54_wb_fifo
    import cpu54_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clock_in,
    input  logic        reset_signal,
    input  logic        push,
    input  wb_entry_t   push_entry,
    input  logic        pop,
    output wb_entry_t   head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Storage carries no reset; only the pointers and count decide validity.
    always_ff @(posedge clock_in) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_signal) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu54_wb_arbiter.sv
// Merges single-cycle pipeline results and buffered multicycle results into one
// registered register-file write per cycle, and tracks busy registers for decode.
module cpu54_wb_arbiter
    import cpu54_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clock_in,
    input  logic                  reset_signal,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0]     a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0]     b_data,
    input  logic                  rsv_valid,
    input  logic [REG_ADDR_W-1:0] rsv_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic                  stall,
    output logic                  wr_enable,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [AW:0]           fifo_count
);

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    wb_entry_t            fifo_head;
    wb_entry_t            fifo_in;
    logic                 a_take;
    logic [NUM_REGS-1:0]  busy;
    logic [NUM_REGS-1:0]  busy_next;

    // Writes to r0 are acknowledged and dropped on both producer paths.
    assign a_take    = a_valid && (a_addr != '0);
    assign b_ready   = !fifo_full;
    assign fifo_push = b_valid && b_ready && (b_addr != '0);
    assign fifo_pop  = !a_take && !fifo_empty;
    assign fifo_in   = '{addr: b_addr, data: b_data};

    cpu54_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clock_in     (clock_in),
        .reset_signal (reset_signal),
        .push         (fifo_push),
        .push_entry   (fifo_in),
        .pop          (fifo_pop),
        .head         (fifo_head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count)
    );

    always_ff @(posedge clock_in) begin
        if (reset_signal) begin
            wr_enable <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else if (a_take) begin
            wr_enable <= 1'b1;
            wr_addr   <= a_addr;
            wr_data   <= a_data;
        end else if (fifo_pop) begin
            wr_enable <= 1'b1;
            wr_addr   <= fifo_head.addr;
            wr_data   <= fifo_head.data;
        end else begin
            wr_enable <= 1'b0;
        end
    end

    // A new reservation beats a retiring write to the same register.
    always_comb begin
        busy_next = busy;
        if (fifo_pop) begin
            busy_next[fifo_head.addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock_in) begin
        if (reset_signal) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign stall = ((rd_addr1 != '0) && busy[rd_addr1]) ||
                   ((rd_addr2 != '0) && busy[rd_addr2]);

endmodule
